// File: rtl/int_ack_ctrl.sv
// Z80 interrupt responder: latches prioritised requests, drives n_int on CPU clock
// strobes, answers the M1+IORQ acknowledge cycle with an IM2 vector.
module int_ack_ctrl #(
  parameter int          NSRC     = 4,
  parameter logic [7:0]  VEC_BASE = 8'hF8,
  parameter int          INT_LEN  = 32
) (
  input  logic            clk28,
  input  logic            rst,
  input  logic            clkcpu_ck,
  input  logic [NSRC-1:0] src_req,
  input  logic [NSRC-1:0] src_en,
  input  logic            m1,
  input  logic            iorq,
  output logic            n_int,
  output logic            vec_oe,
  output logic [7:0]      vec,
  output logic [NSRC-1:0] ack_src,
  output logic [NSRC-1:0] pending
);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_ACK, S_GUARD} state_e;

  localparam logic [5:0] CNT_LAST = 6'(INT_LEN - 1);

  state_e          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            n_int_q, n_int_d;
  logic            vec_oe_q, vec_oe_d;
  logic [7:0]      vec_q, vec_d;
  logic [NSRC-1:0] ack_src_q, ack_src_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic            ack_cyc_q, ack_prev_q;

  logic            ack_rise;
  logic [1:0]      first_idx;
  logic [NSRC-1:0] sel_oh;
  logic [NSRC-1:0] clr;

  assign ack_rise = ack_cyc_q & ~ack_prev_q;
  assign sel_oh   = NSRC'(1) << sel_q;

  // Index 0 has highest priority, so scan downward and let the lowest index win.
  always_comb begin
    first_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pending_q[i]) first_idx = 2'(i);
    end
  end

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    n_int_d   = n_int_q;
    vec_oe_d  = vec_oe_q;
    vec_d     = vec_q;
    ack_src_d = '0;
    clr       = '0;
    unique case (state_q)
      S_IDLE: begin
        if (clkcpu_ck && |pending_q) begin
          sel_d   = first_idx;
          n_int_d = 1'b0;
          cnt_d   = '0;
          state_d = S_ASSERT;
        end else if (ack_rise) begin
          vec_oe_d = 1'b1;
          vec_d    = 8'hFF;
          state_d  = S_ACK;
        end
      end
      S_ASSERT: begin
        if (clkcpu_ck) cnt_d = cnt_q + 6'd1;
        if (ack_rise) begin
          vec_d     = VEC_BASE | {5'b0, sel_q, 1'b0};
          vec_oe_d  = 1'b1;
          n_int_d   = 1'b1;
          ack_src_d = sel_oh;
          clr       = sel_oh;
          state_d   = S_ACK;
        end else if (~|(src_en & sel_oh)) begin
          n_int_d = 1'b1;
          clr     = sel_oh;
          state_d = S_IDLE;
        end else if (clkcpu_ck && cnt_q == CNT_LAST) begin
          n_int_d = 1'b1;
          clr     = sel_oh;
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        if (!ack_cyc_q) begin
          vec_oe_d = 1'b0;
          vec_d    = 8'hFF;
          state_d  = S_GUARD;
        end
      end
      S_GUARD: begin
        if (clkcpu_ck) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A request arriving in the same cycle as its own clear stays pending.
  assign pending_d = (pending_q & ~clr & src_en) | (src_req & src_en);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      n_int_q    <= 1'b1;
      vec_oe_q   <= 1'b0;
      vec_q      <= 8'hFF;
      ack_src_q  <= '0;
      pending_q  <= '0;
      ack_cyc_q  <= 1'b0;
      ack_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      n_int_q    <= n_int_d;
      vec_oe_q   <= vec_oe_d;
      vec_q      <= vec_d;
      ack_src_q  <= ack_src_d;
      pending_q  <= pending_d;
      ack_cyc_q  <= m1 & iorq;
      ack_prev_q <= ack_cyc_q;
    end
  end

  assign n_int   = n_int_q;
  assign vec_oe  = vec_oe_q;
  assign vec     = vec_q;
  assign ack_src = ack_src_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_int_ack_ctrl.sv
// Directed bench for int_ack_ctrl: one CPU cycle is four clk28 cycles with the
// strobe on the first; outputs are sampled 1 ns after each clk28 edge.
module tb_int_ack_ctrl;

  logic       clk28 = 1'b0;
  logic       rst;
  logic       clkcpu_ck;
  logic [3:0] src_req;
  logic [3:0] src_en;
  logic       m1;
  logic       iorq;
  logic       n_int;
  logic       vec_oe;
  logic [7:0] vec;
  logic [3:0] ack_src;
  logic [3:0] pending;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  int ack_snap;

  int_ack_ctrl #(.NSRC(4), .VEC_BASE(8'hF8), .INT_LEN(32)) dut (
    .clk28     (clk28),
    .rst       (rst),
    .clkcpu_ck (clkcpu_ck),
    .src_req   (src_req),
    .src_en    (src_en),
    .m1        (m1),
    .iorq      (iorq),
    .n_int     (n_int),
    .vec_oe    (vec_oe),
    .vec       (vec),
    .ack_src   (ack_src),
    .pending   (pending)
  );

  always #5 clk28 = ~clk28;

  always @(posedge clk28) if (ack_src !== 4'b0) ack_cnt++;

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  task automatic cpu(input int n);
    for (int i = 0; i < n; i++) begin
      clkcpu_ck = 1'b1;
      tick();
      clkcpu_ck = 1'b0;
      tick();
      tick();
      tick();
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; clkcpu_ck = 1'b0; src_req = 4'b0; src_en = 4'hF; m1 = 1'b0; iorq = 1'b0;
    tick();
    tick();
    check("rst_n_int",   n_int,   1);
    check("rst_vec_oe",  vec_oe,  0);
    check("rst_vec",     vec,     8'hFF);
    check("rst_ack_src", ack_src, 0);
    check("rst_pending", pending, 0);
    rst = 1'b0;
    tick();

    // 1: source 1, no acknowledge -> 32 CPU cycles low, then timeout
    ack_snap = ack_cnt;
    src_req = 4'b0010;
    tick();
    src_req = 4'b0;
    check("t1_pending_set", pending, 4'b0010);
    check("t1_n_int_idle",  n_int, 1);
    cpu(1);
    check("t1_n_int_low",   n_int, 0);
    cpu(31);
    check("t1_n_int_still_low", n_int, 0);
    cpu(1);
    check("t1_n_int_timeout", n_int, 1);
    check("t1_pending_clr",   pending, 0);
    check("t1_no_ack",        ack_cnt - ack_snap, 0);

    // 2: source 2 acknowledged after 5 CPU cycles
    src_req = 4'b0100;
    tick();
    src_req = 4'b0;
    cpu(5);
    check("t2_n_int_low", n_int, 0);
    m1 = 1'b1; iorq = 1'b1;
    tick();
    check("t2_vec_oe_lat1", vec_oe, 0);
    tick();
    check("t2_vec_oe", vec_oe, 1);
    check("t2_vec",    vec, 8'hFC);
    check("t2_ack_src", ack_src, 4'b0100);
    check("t2_n_int",  n_int, 1);
    check("t2_pending", pending, 0);
    tick();
    check("t2_ack_pulse_end", ack_src, 0);
    check("t2_vec_oe_held",   vec_oe, 1);
    m1 = 1'b0; iorq = 1'b0;
    tick();
    tick();
    check("t2_vec_oe_off", vec_oe, 0);
    check("t2_vec_ff",     vec, 8'hFF);
    cpu(1);

    // 3: sources 1 and 3 together -> served in priority order with a guard gap
    src_req = 4'b1010;
    tick();
    src_req = 4'b0;
    check("t3_pending", pending, 4'b1010);
    cpu(1);
    check("t3_n_int_low1", n_int, 0);
    m1 = 1'b1; iorq = 1'b1;
    tick();
    tick();
    check("t3_vec1",     vec, 8'hFA);
    check("t3_ack_src1", ack_src, 4'b0010);
    check("t3_pending1", pending, 4'b1000);
    m1 = 1'b0; iorq = 1'b0;
    tick();
    tick();
    check("t3_vec_oe_off1", vec_oe, 0);
    cpu(1);
    check("t3_guard_n_int", n_int, 1);
    cpu(1);
    check("t3_n_int_low2", n_int, 0);
    m1 = 1'b1; iorq = 1'b1;
    tick();
    tick();
    check("t3_vec2",     vec, 8'hFE);
    check("t3_ack_src2", ack_src, 4'b1000);
    check("t3_pending2", pending, 0);
    m1 = 1'b0; iorq = 1'b0;
    tick();
    tick();
    cpu(1);

    // 4: mask source 0 while its interrupt is asserted
    src_req = 4'b0001;
    tick();
    src_req = 4'b0;
    cpu(3);
    check("t4_n_int_low", n_int, 0);
    src_en = 4'b1110;
    tick();
    check("t4_n_int_mask", n_int, 1);
    check("t4_pending",    pending, 0);
    src_req = 4'b0001;
    tick();
    src_req = 4'b0;
    check("t4_masked_req", pending, 0);
    cpu(1);
    check("t4_idle_n_int", n_int, 1);
    src_en = 4'hF;

    // 5: spurious acknowledge with nothing pending
    m1 = 1'b1; iorq = 1'b1;
    tick();
    tick();
    check("t5_vec_oe",   vec_oe, 1);
    check("t5_vec",      vec, 8'hFF);
    check("t5_ack_src",  ack_src, 0);
    check("t5_n_int",    n_int, 1);
    m1 = 1'b0; iorq = 1'b0;
    tick();
    tick();
    check("t5_vec_oe_off", vec_oe, 0);
    cpu(1);

    // 6: asynchronous reset while in ACK, then normal operation
    src_req = 4'b0100;
    tick();
    src_req = 4'b0;
    cpu(1);
    m1 = 1'b1; iorq = 1'b1;
    tick();
    tick();
    src_req = 4'b0010;
    tick();
    src_req = 4'b0;
    check("t6_in_ack",   vec_oe, 1);
    check("t6_pend_pre", pending, 4'b0010);
    rst = 1'b1;
    #2;
    check("t6_rst_vec_oe",  vec_oe, 0);
    check("t6_rst_n_int",   n_int, 1);
    check("t6_rst_pending", pending, 0);
    m1 = 1'b0; iorq = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    src_req = 4'b0001;
    tick();
    src_req = 4'b0;
    cpu(1);
    check("t6_n_int_low", n_int, 0);
    m1 = 1'b1; iorq = 1'b1;
    tick();
    tick();
    check("t6_vec",     vec, 8'hF8);
    check("t6_ack_src", ack_src, 4'b0001);
    m1 = 1'b0; iorq = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
